// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared widths, reset default and queue-entry type for thumb_fetch.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int INDEX_W = 32;
  localparam int INSTR_W = 16;

  localparam logic [INDEX_W-1:0] DEFAULT_RESET_INDEX = '0;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Halfword index increment; wraps naturally at 2^32.
  function automatic logic [INDEX_W-1:0] next_index(input logic [INDEX_W-1:0] idx);
    return idx + INDEX_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/thumb_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : thumb_fetch_if
// Purpose  : Branch, icache and decode-side signals of the Thumb fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
interface thumb_fetch_if;
  import fetch_pkg::*;

  logic               branch_valid;
  logic [INDEX_W-1:0] branch_target;
  logic               ic_not_enable;
  logic [INDEX_W-1:0] ic_index;
  logic [INSTR_W-1:0] ic_data;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [INDEX_W-1:0] instr_index;
  logic               instr_ready;

  // Fetch stage side.
  modport master (
    input  branch_valid, branch_target, ic_data, instr_ready,
    output ic_not_enable, ic_index, instr_valid, instr, instr_index
  );

  // Environment side: branch unit, icache and decode.
  modport slave (
    output branch_valid, branch_target, ic_data, instr_ready,
    input  ic_not_enable, ic_index, instr_valid, instr, instr_index
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Synchronous prefetch FIFO of {index, instr} entries with flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  fetch_entry_t       i_push_entry,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_empty,
  output fetch_entry_t       o_head
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/thumb_fetch.sv
`default_nettype none
// ============================================================================
// Module   : thumb_fetch
// Purpose  : Halfword fetch stage feeding decode from icache via a prefetch
//            queue; FETCH_BYPASS_EN lets an empty queue forward the response.
// Revision : 1.0 - initial release
// ============================================================================
module thumb_fetch
  import fetch_pkg::*;
#(
  parameter logic [INDEX_W-1:0] RESET_INDEX = DEFAULT_RESET_INDEX,
  parameter int                 QUEUE_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  thumb_fetch_if.master bus
);

  localparam int c_cnt_w = $clog2(QUEUE_DEPTH) + 1;

  logic [INDEX_W-1:0] r_fetch_idx;
  logic [INDEX_W-1:0] r_inflight_idx;
  logic               r_inflight;

  logic [c_cnt_w-1:0] w_count;
  logic [c_cnt_w:0]   w_occupancy;
  logic               w_q_empty;
  fetch_entry_t       w_head;
  fetch_entry_t       w_resp_entry;
  fetch_entry_t       w_out;
  logic               w_issue;
  logic               w_resp;
  logic               w_push;
  logic               w_pop;
  logic               w_valid;

  // Space is reserved for the in-flight read; a same-cycle pop is not credited.
  assign w_occupancy = {1'b0, w_count} + {{c_cnt_w{1'b0}}, r_inflight};
  assign w_issue     = !reset && !bus.branch_valid
                       && (w_occupancy < (c_cnt_w + 1)'(QUEUE_DEPTH));

  // A response is squashed by a branch or reset in its arrival cycle.
  assign w_resp       = r_inflight && !bus.branch_valid && !reset;
  assign w_resp_entry = '{index: r_inflight_idx, instr: bus.ic_data};

`ifdef FETCH_BYPASS_EN
  logic w_bypass;
  assign w_bypass = w_resp && w_q_empty;
  assign w_valid  = !reset && (!w_q_empty || w_bypass);
  assign w_out    = w_bypass ? w_resp_entry : w_head;
  assign w_push   = w_resp && !(w_bypass && bus.instr_ready);
`else
  assign w_valid  = !reset && !w_q_empty;
  assign w_out    = w_head;
  assign w_push   = w_resp;
`endif

  assign w_pop = w_valid && bus.instr_ready && !w_q_empty;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (reset),
    .i_push       (w_push),
    .i_push_entry (w_resp_entry),
    .i_pop        (w_pop),
    .i_flush      (bus.branch_valid),
    .o_count      (w_count),
    .o_empty      (w_q_empty),
    .o_head       (w_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_idx    <= RESET_INDEX;
      r_inflight     <= 1'b0;
      r_inflight_idx <= '0;
    end else if (bus.branch_valid) begin
      r_fetch_idx <= bus.branch_target;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_idx <= r_fetch_idx;
        r_fetch_idx    <= next_index(r_fetch_idx);
      end
    end
  end

  assign bus.ic_not_enable = !w_issue;
  assign bus.ic_index      = r_fetch_idx;
  assign bus.instr_valid   = w_valid;
  assign bus.instr         = reset ? '0 : w_out.instr;
  assign bus.instr_index   = reset ? '0 : w_out.index;

endmodule
`default_nettype wire

// File: tb/tb_thumb_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_thumb_fetch
// Purpose  : Self-checking bench for thumb_fetch against a queue-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_thumb_fetch;
  import fetch_pkg::*;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] RST_IDX = 32'h0;
`ifdef FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  thumb_fetch_if bus();

  thumb_fetch #(
    .RESET_INDEX (RST_IDX),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic logic [15:0] mem_word(input logic [31:0] idx);
    return 16'(32'h1000 + idx);
  endfunction

  // icache: one-cycle read latency, zero when not enabled.
  always @(posedge clk) bus.ic_data <= bus.ic_not_enable ? 16'h0 : mem_word(bus.ic_index);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: prefetch queue contents, fetch pointer, pending read.
  typedef struct {
    logic [31:0] idx;
    logic [15:0] word;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fetch    = RST_IDX;
  bit          m_infl     = 1'b0;
  logic [31:0] m_infl_idx = 32'h0;
  bit          model_on   = 1'b0;

  always @(negedge clk) begin
    if (model_on) begin
      if (reset) begin
        check("rst_valid", bus.instr_valid, 1'b0);
        check("rst_ne", bus.ic_not_enable, 1'b1);
        check("rst_instr", bus.instr, 16'h0);
        check("rst_index", bus.instr_index, 32'h0);
        mq.delete();
        m_fetch = RST_IDX;
        m_infl  = 1'b0;
      end else begin
        bit   resp, byp, ev, iss, accepted;
        ent_t he;
        resp = m_infl && !bus.branch_valid;
        byp  = BYPASS && resp && (mq.size() == 0);
        ev   = (mq.size() > 0) || byp;
        if (mq.size() > 0) he = mq[0];
        else he = '{m_infl_idx, mem_word(m_infl_idx)};
        iss = !bus.branch_valid && ((mq.size() + int'(m_infl)) < DEPTH);
        check("ic_not_enable", bus.ic_not_enable, !iss);
        check("ic_index", bus.ic_index, m_fetch);
        check("instr_valid", bus.instr_valid, ev);
        if (ev) begin
          check("instr", bus.instr, he.word);
          check("instr_index", bus.instr_index, he.idx);
        end
        accepted = ev && bus.instr_ready;
        if (bus.branch_valid) begin
          mq.delete();
          m_fetch = bus.branch_target;
          m_infl  = 1'b0;
        end else begin
          if (accepted && mq.size() > 0) void'(mq.pop_front());
          if (resp && !(byp && accepted)) mq.push_back('{m_infl_idx, mem_word(m_infl_idx)});
          if (iss) begin
            m_infl_idx = m_fetch;
            m_fetch    = m_fetch + 32'h1;
          end
          m_infl = iss;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int          first;
    int          n;
    int          issues;
    int          lat;
    int          k;
    int          bad;
    logic [31:0] idx_first;
    logic [31:0] wrap_exp [4];
    wrap_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};

    bus.branch_valid  = 1'b0;
    bus.branch_target = 32'h0;
    bus.instr_ready   = 1'b1;
    reset             = 1'b1;
    model_on          = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Free-running start from reset.
    first = -1;
    n     = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("p1_ic_index", bus.ic_index, 32'(c));
      if (bus.instr_valid) begin
        if (first < 0) first = c;
        check("p1_instr", bus.instr, 16'(16'h1000 + n));
        check("p1_index", bus.instr_index, 32'(n));
        n++;
      end
      tick();
    end
    check("p1_first_valid_cycle", 32'(first), BYPASS ? 32'd1 : 32'd2);

    // Stall: exactly DEPTH reads, then drain in order.
    bus.instr_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    issues = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!bus.ic_not_enable) issues++;
      tick();
    end
    check("p2_issue_count", 32'(issues), 32'd4);
    @(negedge clk);
    check("p2_ne_held", bus.ic_not_enable, 1'b1);
    check("p2_head", bus.instr, 16'h1000);
    tick();
    bus.instr_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.instr_valid) begin
        check("p2_drain_index", bus.instr_index, 32'(n));
        check("p2_drain_instr", bus.instr, 16'(16'h1000 + n));
        n++;
      end
      tick();
    end
    check("p2_drain_count", 32'(n), 32'd12);

    // Branch with two queued entries and a read in flight.
    bus.instr_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'h40;
    @(negedge clk);
    check("p3_pre_valid", bus.instr_valid, 1'b1);
    check("p3_b_ne", bus.ic_not_enable, 1'b1);
    tick();
    bus.branch_valid = 1'b0;
    bus.instr_ready  = 1'b1;
    @(negedge clk);
    check("p3_b1_valid", bus.instr_valid, 1'b0);
    check("p3_b1_ic_index", bus.ic_index, 32'h40);
    check("p3_b1_ne", bus.ic_not_enable, 1'b0);
    lat = 1;
    while (!bus.instr_valid && lat < 10) begin
      tick();
      lat++;
      @(negedge clk);
    end
    check("p3_latency", 32'(lat), BYPASS ? 32'd2 : 32'd3);
    check("p3_index", bus.instr_index, 32'h40);
    check("p3_instr", bus.instr, 16'h1040);
    tick();

    // Branch near the top of the index space: wrap to zero.
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'hFFFF_FFFE;
    tick();
    bus.branch_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 12 && k < 4; c++) begin
      @(negedge clk);
      if (bus.instr_valid) begin
        check("p4_wrap_index", bus.instr_index, wrap_exp[k]);
        k++;
      end
      tick();
    end
    check("p4_wrap_count", 32'(k), 32'd4);

    // Reset mid-stream with three entries queued.
    bus.instr_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    @(negedge clk);
    check("p5_rst_valid", bus.instr_valid, 1'b0);
    check("p5_rst_ne", bus.ic_not_enable, 1'b1);
    tick();
    reset = 1'b0;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("p5_restart_index", bus.ic_index, RST_IDX);
    lat = 0;
    while (!bus.instr_valid && lat < 10) begin
      tick();
      lat++;
      @(negedge clk);
    end
    check("p5_first_index", bus.instr_index, RST_IDX);
    check("p5_first_instr", bus.instr, 16'h1000);
    tick();

    // Back-to-back branches: the later target wins.
    bus.branch_valid  = 1'b1;
    bus.branch_target = 32'h10;
    tick();
    bus.branch_target = 32'h20;
    tick();
    bus.branch_valid = 1'b0;
    bad       = 0;
    idx_first = 32'hDEAD_BEEF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.instr_valid) begin
        if (idx_first == 32'hDEAD_BEEF) idx_first = bus.instr_index;
        if (bus.instr_index[31:4] == 28'h1) bad++;
      end
      tick();
    end
    check("p6_first_index", idx_first, 32'h20);
    check("p6_no_0x10_stream", 32'(bad), 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      bus.instr_ready   = ($urandom_range(0, 99) < 70);
      bus.branch_valid  = ($urandom_range(0, 99) < 4);
      bus.branch_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                                      : 32'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset            = 1'b0;
    bus.branch_valid = 1'b0;
    bus.instr_ready  = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
